// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the ram_arbiter slice: FSM state encodings and
// requester index constants.
package ram_arbiter_pkg;

  // Two-bit state encoding for the grant / access / respond sequence
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_RESP   = 2'd2
  } state_t;

  // Requester identifiers as carried in grant_id and last_grant
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Two-way request picker for ram_arbiter.
// Optional feature macro: RAM_ARBITER_ROUND_ROBIN_EN
//   defined   -> contention goes to the requester that was not granted last
//   undefined -> fixed priority, requester 0 always wins contention
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifndef RAM_ARBITER_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history entirely
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Choose a winner whenever at least one requester is asking
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = REQ0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (req1) begin
      grant_id = REQ1;
    end
`else
    if (!req0 && req1) begin
      grant_id = REQ1;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two req/ack requesters.
// Each access runs IDLE (grant) -> ACCESS (RAM cycle) -> RESP (ack pulse).
// Optional feature macro: RAM_ARBITER_ROUND_ROBIN_EN (round-robin contention;
// fixed priority to requester 0 when undefined).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [ADDRESS_BITS-1:0] addr0,
  input  logic [DATA_BITS-1:0]    wdata0,
  output logic                    ack0,
  output logic [DATA_BITS-1:0]    rdata0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [ADDRESS_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0]    wdata1,
  output logic                    ack1,
  output logic [DATA_BITS-1:0]    rdata1,
  output logic                    ram_write,
  output logic [ADDRESS_BITS-1:0] ram_address,
  inout  wire  [DATA_BITS-1:0]    ram_data
);

  state_t                 state;
  logic                   gid_q;
  logic                   we_q;
  logic [DATA_BITS-1:0]   wdata_q;
  logic                   grant_valid;
  logic                   grant_id;
  logic                   pick_last;
  logic                   sel_we;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0]   sel_wdata;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_grant;
  assign pick_last = last_grant;
`else
  assign pick_last = REQ1;
`endif

  ram_arbiter_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (pick_last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // The bus is only driven while a write is in its ACCESS cycle
  assign ram_data = ram_write ? wdata_q : {DATA_BITS{1'bz}};

  // Route the winning requester's command fields to the capture registers
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (grant_id == REQ1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Arbitration FSM with registered RAM controls, acks and read data
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= STATE_IDLE;
      gid_q       <= REQ0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      last_grant  <= REQ1;
`endif
    end else begin
      case (state)
        STATE_IDLE: begin
          if (grant_valid) begin
            gid_q       <= grant_id;
            we_q        <= sel_we;
            wdata_q     <= sel_wdata;
            ram_address <= sel_addr;
            ram_write   <= sel_we;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            last_grant  <= grant_id;
`endif
            state       <= STATE_ACCESS;
          end
        end
        STATE_ACCESS: begin
          ram_write <= 1'b0;
          if (!we_q) begin
            if (gid_q == REQ1) begin
              rdata1 <= ram_data;
            end else begin
              rdata0 <= ram_data;
            end
          end
          ack0  <= (gid_q == REQ0);
          ack1  <= (gid_q == REQ1);
          state <= STATE_RESP;
        end
        STATE_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= STATE_IDLE;
        end
        default: begin
          ram_write <= 1'b0;
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          state     <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule
